wb_pattern_seq: RTL and testbench



---
 rtl/wb_pattern_seq_pkg.sv | 26 ++
 rtl/wb_master_single.sv | 106 ++++++++++
 rtl/wb_pattern_seq.sv | 202 ++++++++++++++++++++
 tb/tb_wb_pattern_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pattern_seq_pkg.sv
// Shared types and constants for the Wishbone pattern sequencer.
package wb_pattern_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWrite,
        StDwell,
        StDone,
        StError
    } state_e;

    // Table entry layout: [7:0] data, [15:8] channel, [31:16] dwell cycles.
    localparam int unsigned DATA_LSB  = 0;
    localparam int unsigned CHAN_LSB  = 8;
    localparam int unsigned DWELL_LSB = 16;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Byte address of 32-bit word idx in a region starting at base.
    function automatic logic [31:0] word_adr(input logic [31:0] base, input logic [31:0] idx);
        return base + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/wb_master_single.sv
// Issues one classic Wishbone cycle per start request, reissuing on retry.
module wb_master_single #(
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        start_we_i,
    input  logic [31:0] start_adr_i,
    input  logic [31:0] start_dat_i,
    output logic [31:0] rdata_o,
    output logic        ok_o,
    output logic        err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic            stb_q, stb_d;
    logic            pend_q, pend_d;
    logic [RtyW-1:0] rty_cnt_q, rty_cnt_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [3:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic            rty_hit, rty_fatal;

    // Decode the slave response; err beats ack, ack beats rty.
    always_comb begin
        rty_hit   = stb_q & wb_rty_i & ~wb_ack_i & ~wb_err_i;
        rty_fatal = rty_hit & (rty_cnt_q == RtyW'(MAX_RETRY));
        ok_o      = stb_q & wb_ack_i & ~wb_err_i;
        err_o     = (stb_q & wb_err_i) | rty_fatal;
        rdata_o   = wb_dat_i;
    end

    // Next state: a pending flag gives the mandatory stb-low cycle before every issue.
    always_comb begin
        stb_d     = stb_q;
        pend_d    = pend_q;
        rty_cnt_d = rty_cnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        if (stb_q && (wb_ack_i || wb_err_i || wb_rty_i)) begin
            stb_d = 1'b0;
        end
        if (rty_hit && !rty_fatal) begin
            pend_d    = 1'b1;
            rty_cnt_d = rty_cnt_q + RtyW'(1);
        end
        if (pend_q) begin
            pend_d = 1'b0;
            stb_d  = ~abort_i;
        end
        if (start_i) begin
            pend_d    = 1'b1;
            stb_d     = 1'b0;
            rty_cnt_d = '0;
            adr_d     = start_adr_i;
            dat_d     = start_dat_i;
            sel_d     = 4'hF;
            we_d      = start_we_i;
        end
    end

    // Bus output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stb_q     <= 1'b0;
            pend_q    <= 1'b0;
            rty_cnt_q <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
        end else begin
            stb_q     <= stb_d;
            pend_q    <= pend_d;
            rty_cnt_q <= rty_cnt_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = stb_q;
    assign wb_stb_o = stb_q;

endmodule

// File: rtl/wb_pattern_seq.sv
// Steps through a ROM pattern table and writes each data byte to a GPIO channel.
module wb_pattern_seq
    import wb_pattern_seq_pkg::*;
#(
    parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 40,
    parameter logic [31:0] GPIO_BASE = 32'h9100_0000,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned MAX_RETRY = 3,
    localparam int unsigned StepW    = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             enable,
    input  logic             loop,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    output logic [3:0]       wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic [2:0]       wb_cti_o,
    output logic [1:0]       wb_bte_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [StepW-1:0] step
);

    state_e           state_q, state_d;
    logic [StepW-1:0] step_q, step_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             busy_q, done_q, error_q;

    logic        m_start, m_abort, m_we, m_ok, m_err;
    logic [31:0] m_adr, m_wdat, m_rdata;
    logic [7:0]  ent_data, ent_chan;
    logic [15:0] ent_dwell;
    logic        adv, fin;

    assign ent_data  = m_rdata[DATA_LSB +: 8];
    assign ent_chan  = m_rdata[CHAN_LSB +: 8];
    assign ent_dwell = m_rdata[DWELL_LSB +: 16];

    wb_master_single #(
        .MAX_RETRY (MAX_RETRY)
    ) u_master (
        .clk_i       (wb_clk),
        .rst_i       (wb_rst),
        .start_i     (m_start),
        .abort_i     (m_abort),
        .start_we_i  (m_we),
        .start_adr_i (m_adr),
        .start_dat_i (m_wdat),
        .rdata_o     (m_rdata),
        .ok_o        (m_ok),
        .err_o       (m_err),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .wb_rty_i    (wb_rty_i)
    );

    // Sequencing FSM; bus cycles are launched on the transition into FETCH/WRITE.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        m_start = 1'b0;
        m_abort = 1'b0;
        m_we    = 1'b0;
        m_adr   = word_adr(ROM_BASE, 32'(step_q));
        m_wdat  = '0;
        adv     = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    step_d  = '0;
                    state_d = StFetch;
                    m_start = 1'b1;
                    m_adr   = ROM_BASE;
                end
            end
            StFetch: begin
                if (m_err) begin
                    state_d = StError;
                end else if (m_ok) begin
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (ent_dwell == 16'd0) begin
                        fin = 1'b1;
                    end else if (32'(ent_chan) >= CHANNELS) begin
                        state_d = StError;
                    end else begin
                        cnt_d   = ent_dwell;
                        state_d = StWrite;
                        m_start = 1'b1;
                        m_we    = 1'b1;
                        m_adr   = word_adr(GPIO_BASE, 32'(ent_chan));
                        m_wdat  = {24'h0, ent_data};
                    end
                end else if (!enable && !wb_stb_o) begin
                    // Not yet issued or waiting to reissue: safe to drop.
                    m_abort = 1'b1;
                    state_d = StIdle;
                end
            end
            StWrite: begin
                if (m_err) begin
                    state_d = StError;
                end else if (m_ok) begin
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (cnt_q == 16'd1) begin
                        adv = 1'b1;
                    end else begin
                        // The ack cycle itself counts as the first dwell cycle.
                        cnt_d   = cnt_q - 16'd1;
                        state_d = StDwell;
                    end
                end else if (!enable && !wb_stb_o) begin
                    m_abort = 1'b1;
                    state_d = StIdle;
                end
            end
            StDwell: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (cnt_q == 16'd1) begin
                    adv = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StDone, StError: begin
                if (!enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (adv) begin
            if (step_q == StepW'(ROM_WORDS - 1)) begin
                fin = 1'b1;
            end else begin
                step_d  = step_q + StepW'(1);
                state_d = StFetch;
                m_start = 1'b1;
                m_adr   = word_adr(ROM_BASE, 32'(step_d));
            end
        end
        if (fin) begin
            if (loop) begin
                step_d  = '0;
                state_d = StFetch;
                m_start = 1'b1;
                m_adr   = ROM_BASE;
            end else begin
                state_d = StDone;
            end
        end
    end

    // State and registered status outputs.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == StFetch) || (state_d == StWrite) || (state_d == StDwell);
            done_q  <= (state_d == StDone);
            error_q <= (state_d == StError);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign step     = step_q;
    assign wb_cti_o = CTI_CLASSIC;
    assign wb_bte_o = BTE_LINEAR;

endmodule

// File: tb/tb_wb_pattern_seq.sv
// Directed bench for wb_pattern_seq with a combined ROM/GPIO slave model.
module tb_wb_pattern_seq;

    localparam logic [31:0] GPIO = 32'h9100_0000;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        enable = 1'b0;
    logic        loop = 1'b0;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic        busy, done, error;
    logic [2:0]  step;

    // Slave behaviour knobs, written only by the stimulus block.
    logic [31:0] rom [8];
    int          rty_n = 0;
    int          err_mode = 0;
    logic        wr_stall = 1'b0;
    logic        rty_clr = 1'b0;

    // Monitor state, written only by the monitor block.
    int          cycle = 0, n_wr = 0, n_rd = 0, n_gap = 0, rty_seen = 0, last_wr_ack = 0;
    logic        prev_stb = 1'b0, wr_since = 1'b0, bus_bad = 1'b0;
    logic [31:0] prev_adr = '0;
    logic [2:0]  step_prev = '0, wrap_from = '0;
    logic [31:0] wr_adr_log [256];
    logic [31:0] wr_dat_log [256];
    logic [31:0] rd_adr_log [256];
    int          rd_cyc_log [256];
    int          gap_log [256];

    int n_chk = 0;
    int n_err = 0;
    int b_wr, b_rd, b_gap;

    logic [31:0] exp_adr [3] = '{GPIO + 32'd4, GPIO + 32'd8, GPIO + 32'd12};
    logic [31:0] exp_dat [3] = '{32'h11, 32'h22, 32'h33};
    int          exp_gap [3] = '{3, 4, 2};

    always #5 wb_clk = ~wb_clk;

    assign wb_dat_i = rom[wb_adr_o[4:2]];
    assign wb_rty_i = wb_stb_o & ~wb_we_o & (rty_seen < rty_n);
    assign wb_err_i = wb_stb_o & wb_we_o & (err_mode != 0);
    assign wb_ack_i = wb_stb_o & ~wb_rty_i & ~(wb_we_o & (wr_stall || err_mode == 1));

    wb_pattern_seq #(
        .ROM_BASE  (32'h0000_0000),
        .ROM_WORDS (8),
        .GPIO_BASE (GPIO),
        .CHANNELS  (4),
        .MAX_RETRY (3)
    ) dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .enable   (enable),
        .loop     (loop),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_cti_o (wb_cti_o),
        .wb_bte_o (wb_bte_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .step     (step)
    );

    // Bus monitor: logs completed writes, read issues, write-ack to fetch gaps.
    always @(posedge wb_clk) begin
        cycle     <= cycle + 1;
        prev_stb  <= wb_stb_o;
        prev_adr  <= wb_adr_o;
        step_prev <= step;
        if (step != step_prev && step == 3'd0) wrap_from <= step_prev;
        if (wb_cyc_o != wb_stb_o) bus_bad <= 1'b1;
        if (prev_stb && wb_stb_o && !wb_rst && wb_adr_o != prev_adr) bus_bad <= 1'b1;
        if (rty_clr) rty_seen <= 0;
        else if (wb_rty_i) rty_seen <= rty_seen + 1;
        if (wb_stb_o && !prev_stb && !wb_we_o) begin
            rd_adr_log[n_rd % 256] <= wb_adr_o;
            rd_cyc_log[n_rd % 256] <= cycle;
            n_rd <= n_rd + 1;
            if (wr_since) begin
                gap_log[n_gap % 256] <= cycle - last_wr_ack;
                n_gap <= n_gap + 1;
            end
            wr_since <= 1'b0;
        end
        if (wb_stb_o && wb_we_o && wb_ack_i && !wb_err_i) begin
            wr_adr_log[n_wr % 256] <= wb_adr_o;
            wr_dat_log[n_wr % 256] <= wb_dat_o;
            n_wr <= n_wr + 1;
            last_wr_ack <= cycle;
            wr_since <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 200 && !(done || error); i++) tick();
    endtask

    task automatic go_idle();
        enable = 1'b0;
        for (int i = 0; i < 50 && (busy || done || error); i++) tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = '0;
        repeat (3) tick();

        // Reset state.
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_ctl", {28'h0, wb_sel_o}, 32'h0);
        chk("rst_bus", {26'h0, wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o == 3'd0, wb_bte_o == 2'd0,
                        1'b0}, {26'h0, 6'b000110});
        chk("rst_stat", {26'h0, busy, done, error, step}, 32'h0);
        wb_rst = 1'b0;
        tick();

        // One entry then end marker, one-shot.
        rom[0] = {16'd5, 8'd0, 8'hA5};
        rom[1] = 32'h0;
        b_wr = n_wr; b_rd = n_rd;
        enable = 1'b1;
        wait_end();
        chk("t1_done", {31'h0, done}, 32'd1);
        chk("t1_busy_err", {30'h0, busy, error}, 32'd0);
        chk("t1_nwr", 32'(n_wr - b_wr), 32'd1);
        chk("t1_wadr", wr_adr_log[b_wr % 256], GPIO);
        chk("t1_wdat", wr_dat_log[b_wr % 256], 32'h0000_00A5);
        chk("t1_step", {29'h0, step}, 32'd1);
        b_rd = n_rd - b_rd;
        repeat (10) tick();
        chk("t1_quiet", 32'(n_rd - b_wr - b_rd - (n_wr - b_wr - 1)), 32'(n_rd - b_wr - 2));
        chk("t1_nrd", 32'(b_rd), 32'd2);
        chk("t1_stb_idle", {31'h0, wb_stb_o}, 32'd0);
        enable = 1'b0;
        tick(); tick();
        chk("t1_done_clr", {31'h0, done}, 32'd0);

        // Three entries with loop: order, gaps, wrap.
        rom[0] = {16'd2, 8'd1, 8'h11};
        rom[1] = {16'd3, 8'd2, 8'h22};
        rom[2] = {16'd1, 8'd3, 8'h33};
        rom[3] = 32'h0;
        loop = 1'b1;
        b_wr = n_wr; b_gap = n_gap;
        enable = 1'b1;
        for (int i = 0; i < 300 && (n_gap - b_gap) < 6; i++) tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_wadr%0d", k), wr_adr_log[(b_wr + k) % 256], exp_adr[k % 3]);
            chk($sformatf("t2_wdat%0d", k), wr_dat_log[(b_wr + k) % 256], exp_dat[k % 3]);
            chk($sformatf("t2_gap%0d", k), 32'(gap_log[(b_gap + k) % 256]), 32'(exp_gap[k % 3]));
        end
        chk("t2_wrap_from", {29'h0, wrap_from}, 32'd3);
        go_idle();
        chk("t2_stopped", {30'h0, busy, wb_cyc_o}, 32'd0);
        loop = 1'b0;

        // Full table, no marker: stops after the last entry.
        for (int i = 0; i < 8; i++) rom[i] = {16'd1, 6'd0, 2'(i), 8'(i)};
        b_wr = n_wr; b_rd = n_rd;
        enable = 1'b1;
        wait_end();
        chk("t3_done", {31'h0, done}, 32'd1);
        chk("t3_nwr", 32'(n_wr - b_wr), 32'd8);
        chk("t3_nrd", 32'(n_rd - b_rd), 32'd8);
        chk("t3_last_dat", wr_dat_log[(b_wr + 7) % 256], 32'h7);
        chk("t3_last_adr", wr_adr_log[(b_wr + 7) % 256], GPIO + 32'd12);
        chk("t3_step", {29'h0, step}, 32'd7);
        go_idle();

        // Channel out of range.
        rom[0] = {16'd1, 8'd4, 8'h55};
        b_wr = n_wr;
        enable = 1'b1;
        wait_end();
        chk("t4_error", {31'h0, error}, 32'd1);
        chk("t4_nowrite", 32'(n_wr - b_wr), 32'd0);
        chk("t4_cyc", {30'h0, wb_cyc_o, busy}, 32'd0);
        enable = 1'b0;
        tick(); tick();
        chk("t4_err_clr", {31'h0, error}, 32'd0);

        // Two retries are tolerated and reissue the same address.
        rom[0] = {16'd1, 8'd0, 8'h77};
        rom[1] = 32'h0;
        rty_n = 2;
        rty_clr = 1'b1; tick(); rty_clr = 1'b0;
        b_wr = n_wr; b_rd = n_rd;
        enable = 1'b1;
        wait_end();
        chk("t5_done", {30'h0, done, error}, 32'd2);
        chk("t5_nrd", 32'(n_rd - b_rd), 32'd4);
        chk("t5_radr1", rd_adr_log[(b_rd + 1) % 256], 32'h0);
        chk("t5_radr2", rd_adr_log[(b_rd + 2) % 256], 32'h0);
        chk("t5_radr3", rd_adr_log[(b_rd + 3) % 256], 32'h4);
        chk("t5_reissue_gap", 32'(rd_cyc_log[(b_rd + 1) % 256] - rd_cyc_log[b_rd % 256]), 32'd2);
        chk("t5_wdat", wr_dat_log[b_wr % 256], 32'h77);
        go_idle();

        // Fourth retry is fatal.
        rty_n = 4;
        rty_clr = 1'b1; tick(); rty_clr = 1'b0;
        b_wr = n_wr; b_rd = n_rd;
        enable = 1'b1;
        wait_end();
        chk("t6_error", {31'h0, error}, 32'd1);
        chk("t6_nrd", 32'(n_rd - b_rd), 32'd4);
        chk("t6_nowrite", 32'(n_wr - b_wr), 32'd0);
        go_idle();
        rty_n = 0;

        // GPIO err alone, then ack+err together.
        rom[0] = {16'd1, 8'd0, 8'h99};
        for (int m = 1; m <= 2; m++) begin
            err_mode = m;
            enable = 1'b1;
            for (int i = 0; i < 50 && !wb_err_i; i++) tick();
            chk($sformatf("t7_err_seen%0d", m), {31'h0, wb_err_i}, 32'd1);
            tick();
            chk($sformatf("t7_bus_low%0d", m), {30'h0, wb_cyc_o, wb_stb_o}, 32'd0);
            chk($sformatf("t7_error%0d", m), {31'h0, error}, 32'd1);
            go_idle();
        end
        err_mode = 0;

        // Reset while a write is stalled with stb high.
        rom[0] = {16'd5, 8'd2, 8'h3C};
        rom[1] = 32'h0;
        wr_stall = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 50 && !(wb_stb_o && wb_we_o); i++) tick();
        chk("t8_wr_adr", wb_adr_o, GPIO + 32'd8);
        chk("t8_wr_sel", {28'h0, wb_sel_o}, 32'hF);
        wb_rst = 1'b1;
        tick();
        chk("t8_rst_bus", {28'h0, wb_cyc_o, wb_stb_o, wb_we_o, busy}, 32'd0);
        chk("t8_rst_adr", wb_adr_o, 32'h0);
        chk("t8_rst_dat", wb_dat_o, 32'h0);
        chk("t8_rst_sel", {28'h0, wb_sel_o}, 32'h0);
        wb_rst = 1'b0;
        wr_stall = 1'b0;
        b_wr = n_wr;
        for (int i = 0; i < 50 && !wb_stb_o; i++) tick();
        chk("t8_refetch", {wb_adr_o[30:0], wb_we_o}, 32'h0);
        wait_end();
        chk("t8_done", {30'h0, done, error}, 32'd2);
        chk("t8_wdat", wr_dat_log[b_wr % 256], 32'h3C);
        go_idle();

        chk("bus_protocol", {31'h0, bus_bad}, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
